// File: rtl/scan_cfg_loader.sv
// Serializes host configuration words LSB-first onto a scan chain for exactly CHAIN_LEN shifts.
// Define SCAN_READBACK_EN to capture the bits leaving the chain tail and return them as words.
module scan_cfg_loader #(
    parameter int CHAIN_LEN = 20,
    parameter int WIDTH     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] cfg_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             chain_scan_in,
    output logic             chain_scan_en,
    output logic             chain_wen,
    input  logic             chain_scan_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);

    localparam int TW = $clog2(CHAIN_LEN + 1);
    localparam int WW = $clog2(WIDTH + 1);
    localparam logic [TW-1:0] LAST_TOTAL = TW'(CHAIN_LEN - 1);
    localparam logic [WW-1:0] LAST_BIT   = WW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shreg;
    logic [TW-1:0]    r_totalCnt;
    logic [WW-1:0]    r_wordCnt;
    logic             w_lastTotal;
    logic             w_lastBit;

    assign w_lastTotal = (r_totalCnt == LAST_TOTAL);
    assign w_lastBit   = (r_wordCnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The chain total takes priority so a partially used last word ends the load.
    always_comb begin
        w_next        = r_state;
        cfg_ready     = 1'b0;
        chain_scan_in = 1'b0;
        chain_scan_en = 1'b0;
        chain_wen     = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                chain_scan_in = r_shreg[0];
                chain_scan_en = 1'b1;
                chain_wen     = 1'b1;
                if (w_lastTotal) begin
                    w_next = S_DONE;
                end else if (w_lastBit) begin
                    w_next = S_LOAD;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg    <= '0;
            r_totalCnt <= '0;
            r_wordCnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shreg    <= '0;
                        r_totalCnt <= '0;
                        r_wordCnt  <= '0;
                    end
                end
                S_LOAD: begin
                    if (cfg_valid) begin
                        r_shreg   <= cfg_data;
                        r_wordCnt <= '0;
                    end
                end
                S_SHIFT: begin
                    r_shreg    <= r_shreg >> 1;
                    r_totalCnt <= r_totalCnt + TW'(1);
                    r_wordCnt  <= r_wordCnt + WW'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SCAN_READBACK_EN
    logic [WIDTH-1:0] r_rdShreg;
    logic [WIDTH-1:0] r_rdData;
    logic             r_rdValid;
    logic [WW-1:0]    r_rdCnt;
    logic [WIDTH-1:0] w_rdAssembled;

    assign w_rdAssembled = r_rdShreg | (WIDTH'(chain_scan_out) << r_rdCnt);
    assign rd_data       = r_rdData;
    assign rd_valid      = r_rdValid;

    // The tail bit seen during a shift cycle is the one about to fall off the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdShreg <= '0;
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
            r_rdCnt   <= '0;
        end else begin
            r_rdValid <= 1'b0;
            if (r_state == S_IDLE && start) begin
                r_rdShreg <= '0;
                r_rdCnt   <= '0;
            end else if (r_state == S_SHIFT) begin
                if (r_rdCnt == LAST_BIT || w_lastTotal) begin
                    r_rdData  <= w_rdAssembled;
                    r_rdValid <= 1'b1;
                    r_rdShreg <= '0;
                    r_rdCnt   <= '0;
                end else begin
                    r_rdShreg <= w_rdAssembled;
                    r_rdCnt   <= r_rdCnt + WW'(1);
                end
            end
        end
    end
`else
    logic w_unusedScanOut;

    assign w_unusedScanOut = chain_scan_out;
    assign rd_data         = '0;
    assign rd_valid        = 1'b0;
`endif

endmodule

// File: tb/tb_scan_cfg_loader.sv
// Randomized bench for scan_cfg_loader: a behavioural chain plus a positional model of the expected
// chain contents and readback words (readback expectations follow SCAN_READBACK_EN).
module tb_scan_cfg_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  cfgData;
    logic        cfgValid;
    logic        cfgReady;
    logic        chainScanIn;
    logic        chainScanEn;
    logic        chainWen;
    logic        chainScanOut;
    logic        busy;
    logic        done;
    logic [7:0]  rdData;
    logic        rdValid;

    logic        startB;
    logic [7:0]  cfgDataB;
    logic        cfgValidB;
    logic        cfgReadyB;
    logic        chainScanInB;
    logic        chainScanEnB;
    logic        chainWenB;
    logic        chainScanOutB;
    logic        busyB;
    logic        doneB;
    logic [7:0]  rdDataB;
    logic        rdValidB;

    logic [19:0] chainA;
    logic [7:0]  chainB;
    logic        chainLoad;
    logic [19:0] seedA;
    logic [7:0]  seedB;

    int          wenCnt;
    int          doneCnt;
    int          accCnt;
    int          idleViol;
    int          wenCntB;
    logic [7:0]  rdq[$];
    logic [7:0]  wq[3];

    int          total;
    int          bad;

    scan_cfg_loader #(.CHAIN_LEN(20), .WIDTH(8)) dutA (
        .clk(clk), .rst(rst), .start(start), .cfg_data(cfgData), .cfg_valid(cfgValid),
        .cfg_ready(cfgReady), .chain_scan_in(chainScanIn), .chain_scan_en(chainScanEn),
        .chain_wen(chainWen), .chain_scan_out(chainScanOut), .busy(busy), .done(done),
        .rd_data(rdData), .rd_valid(rdValid)
    );

    scan_cfg_loader #(.CHAIN_LEN(8), .WIDTH(8)) dutB (
        .clk(clk), .rst(rst), .start(startB), .cfg_data(cfgDataB), .cfg_valid(cfgValidB),
        .cfg_ready(cfgReadyB), .chain_scan_in(chainScanInB), .chain_scan_en(chainScanEnB),
        .chain_wen(chainWenB), .chain_scan_out(chainScanOutB), .busy(busyB), .done(doneB),
        .rd_data(rdDataB), .rd_valid(rdValidB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural scan chains: head is bit 0, tail is the top bit.
    always @(posedge clk) begin
        if (chainLoad) begin
            chainA <= seedA;
            chainB <= seedB;
        end else begin
            if (chainWen && chainScanEn) chainA <= {chainA[18:0], chainScanIn};
            if (chainWenB && chainScanEnB) chainB <= {chainB[6:0], chainScanInB};
        end
    end
    assign chainScanOut  = chainA[19];
    assign chainScanOutB = chainB[7];

    // Event counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (chainWen) wenCnt <= wenCnt + 1;
        if (done) doneCnt <= doneCnt + 1;
        if (cfgReady && cfgValid) accCnt <= accCnt + 1;
        if (chainScanEn != chainWen || (!chainWen && chainScanIn)) idleViol <= idleViol + 1;
        if (chainWenB) wenCntB <= wenCntB + 1;
        if (rdValid) rdq.push_back(rdData);
    end

    initial begin
        wenCnt = 0; doneCnt = 0; accCnt = 0; idleViol = 0; wenCntB = 0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Chain after n shifts of the wq bit stream: the first bit sent sits deepest (nearest the tail).
    function automatic logic [19:0] expChain(input logic [19:0] old, input int n);
        logic [23:0] bits;
        logic [19:0] res;
        bits = {wq[2], wq[1], wq[0]};
        for (int i = 0; i < 20; i++) begin
            if (i < n) res[i] = bits[n-1-i];
            else       res[i] = old[i-n];
        end
        return res;
    endfunction

    // Readback word j: the prior chain read tail-first, zero beyond the chain length.
    function automatic logic [7:0] expRead(input logic [19:0] pre, input int j);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) begin
            if (j*8 + b < 20) r[b] = pre[19 - (j*8 + b)];
            else              r[b] = 1'b0;
        end
        return r;
    endfunction

    task automatic waitReady();
        int guard;
        guard = 0;
        while (!cfgReady && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("ready_seen", cfgReady, 1);
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (busy && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput("idle_reached", busy, 0);
    endtask

    task automatic applyStimulus(input int dly, input bit midStart, input string tag);
        logic [19:0] pre;
        int w0, d0, a0, r0;
        pre = chainA; w0 = wenCnt; d0 = doneCnt; a0 = accCnt; r0 = rdq.size();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput({tag, "_busy_after_start"}, busy, 1);
        for (int w = 0; w < 3; w++) begin
            cfgData  = wq[w];
            cfgValid = (dly == 0);
            waitReady();
            for (int d = 0; d < dly; d++) begin
                checkOutput({tag, "_wait_ready"}, cfgReady, 1);
                checkOutput({tag, "_wait_wen"}, chainWen, 0);
                @(posedge clk); #1;
            end
            cfgValid = 1'b1;
            @(posedge clk); #1;
            if (dly > 0) cfgValid = 1'b0;
            cfgData = 8'($urandom);
            if (midStart) start = (w < 2);
        end
        cfgValid = 1'b0;
        start    = 1'b0;
        waitIdle();
        @(posedge clk); #1;
        checkOutput({tag, "_shift_cycles"}, wenCnt - w0, 20);
        checkOutput({tag, "_done_pulses"}, doneCnt - d0, 1);
        checkOutput({tag, "_words_taken"}, accCnt - a0, 3);
        checkOutput({tag, "_chain"}, chainA, expChain(pre, 20));
        checkOutput({tag, "_quiet_outside_shift"}, idleViol, 0);
`ifdef SCAN_READBACK_EN
        checkOutput({tag, "_rd_count"}, rdq.size() - r0, 3);
        for (int j = 0; j < 3; j++) begin
            if (r0 + j < rdq.size()) checkOutput({tag, "_rd_word"}, rdq[r0+j], expRead(pre, j));
        end
`else
        checkOutput({tag, "_rd_count"}, rdq.size() - r0, 0);
        checkOutput({tag, "_rd_data"}, rdData, 0);
`endif
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [19:0] snap;
        int w0, cycles;
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; cfgData = '0; cfgValid = 1'b0;
        startB = 1'b0; cfgDataB = '0; cfgValidB = 1'b0;
        seedA = 20'($urandom); seedB = 8'($urandom); chainLoad = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chainLoad = 1'b0;
        checkOutput("rst_cfg_ready", cfgReady, 0);
        checkOutput("rst_scan_in", chainScanIn, 0);
        checkOutput("rst_scan_en", chainScanEn, 0);
        checkOutput("rst_wen", chainWen, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_rd_data", rdData, 0);
        checkOutput("rst_rd_valid", rdValid, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        wq[0] = 8'hA5; wq[1] = 8'h3C; wq[2] = 8'h0F;
        applyStimulus(0, 1'b0, "basic");
        applyStimulus(5, 1'b0, "delayed");
        applyStimulus(0, 1'b1, "mid_start");

        for (int it = 0; it < 4; it++) begin
            for (int w = 0; w < 3; w++) wq[w] = 8'($urandom);
            applyStimulus(int'($urandom_range(0, 4)), it[0], "random");
        end

        // Abort a load with reset after 10 shift cycles.
        wq[0] = 8'hA5; wq[1] = 8'h3C; wq[2] = 8'h00;
        snap = chainA; w0 = wenCnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfgData = 8'hA5; cfgValid = 1'b1;
        waitReady();
        @(posedge clk); #1;
        cfgData = 8'h3C;
        cycles = 0;
        while (wenCnt - w0 < 10 && cycles < 100) begin
            @(negedge clk); #1;
            cycles++;
        end
        checkOutput("abort_shifts_seen", wenCnt - w0, 10);
        rst = 1'b1; cfgValid = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_cfg_ready", cfgReady, 0);
        checkOutput("abort_wen", chainWen, 0);
        checkOutput("abort_scan_en", chainScanEn, 0);
        checkOutput("abort_scan_in", chainScanIn, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_rd_valid", rdValid, 0);
        checkOutput("abort_rd_data", rdData, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort_chain_held", chainA, expChain(snap, 10));
        checkOutput("abort_no_more_shift", wenCnt - w0, 10);

        wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33;
        applyStimulus(1, 1'b0, "after_reset");

        // Single-word chain: 8 shifts, one load, start and done cycles.
        startB = 1'b1; cfgDataB = 8'hFF; cfgValidB = 1'b1;
        w0 = wenCntB;
        cycles = 1;
        @(posedge clk); #1;
        startB = 1'b0;
        cycles++;
        while (!doneB && cycles < 50) begin
            @(posedge clk); #1;
            cycles++;
        end
        cfgValidB = 1'b0;
        checkOutput("single_load_cycles", cycles, 11);
        checkOutput("single_busy_at_done", busyB, 1);
        @(posedge clk); #1;
        checkOutput("single_busy_after_done", busyB, 0);
        checkOutput("single_done_pulse", doneB, 0);
        checkOutput("single_shift_cycles", wenCntB - w0, 8);
        checkOutput("single_chain", chainB, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
